// File: rtl/weight_rd_responder.sv
// ---------------------------------------------------------------------------
// weight_rd_responder
//
// Memory-side responder for the weight-fetch read channel. It holds a
// DEPTH x DW weight RAM that is preloaded through a simple write port. It
// accepts burst read requests and streams back one word per cycle with no
// bubbles.
//
// Parameters
//   DW     data word width
//   AW     request address width (word addresses)
//   DEPTH  RAM depth in words, power of 2
//
// Ports
//   clk      sole clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   wr_en    preload write strobe (accepted in any state)
//   wr_addr  preload word address
//   wr_data  preload data
//   araddr   burst start word address (only the low log2(DEPTH) bits are used)
//   arvalid  request valid; the requester holds it until arready is seen
//   arburst  burst length minus one (1..16 beats)
//   arready  high when a request can be accepted
//   rdata    read data beat
//   rvalid   rdata valid; there is no backpressure
//   rlast    final beat of a burst
//   busy     burst in progress
// ---------------------------------------------------------------------------
module weight_rd_responder #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [AW-1:0]            araddr,
    input  logic                     arvalid,
    input  logic [3:0]               arburst,
    output logic                     arready,
    output logic [DW-1:0]            rdata,
    output logic                     rvalid,
    output logic                     rlast,
    output logic                     busy
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [DW-1:0]   mem [DEPTH];
    logic [IW-1:0]   rd_addr;
    logic [4:0]      beat_cnt;
    logic [3:0]      burst_m1;
    logic            issue;
    logic            last_issue;
    logic            accept;

    // Address bits above the RAM index are deliberately ignored.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^araddr;

    // Next-state and handshake decode. In BURST one RAM read is issued
    // every cycle; the cycle that issues read N-1 also hands control back
    // to IDLE, so a new request can be taken while that beat is in flight.
    always_comb begin
        next_state = state;
        arready    = 1'b0;
        busy       = 1'b0;
        issue      = 1'b0;
        accept     = 1'b0;
        last_issue = (beat_cnt == {1'b0, burst_m1});
        case (state)
            IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    accept     = 1'b1;
                    next_state = BURST;
                end
            end
            BURST: begin
                busy  = 1'b1;
                issue = 1'b1;
                if (last_issue) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register, burst address/beat tracking and the valid/last
    // pipeline that lines up with the registered RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            beat_cnt <= '0;
            burst_m1 <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
        end else begin
            state  <= next_state;
            rvalid <= issue;
            rlast  <= issue && last_issue;
            if (accept) begin
                rd_addr  <= araddr[IW-1:0];
                burst_m1 <= arburst;
                beat_cnt <= '0;
            end else if (issue) begin
                // Natural modulo-DEPTH wrap of the index register.
                rd_addr  <= rd_addr + IW'(1);
                beat_cnt <= beat_cnt + 5'd1;
            end
        end
    end

    // Weight RAM write port. Contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port. Reading and writing the same word in one cycle
    // returns the old contents because both updates are non-blocking.
    // rdata only moves when a read is issued, so it holds between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (issue) begin
            rdata <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_weight_rd_responder.sv
module tb_weight_rd_responder;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic [3:0]    arburst;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rlast;
    logic          busy;

    weight_rd_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arburst (arburst),
        .arready (arready),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rlast   (rlast),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint        cyc;
        int unsigned   addr;
        bit            last;
    } read_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        longint        due;
    } beat_t;

    read_t         sched[$];
    beat_t         expq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    longint        cyc = 0;
    longint        free_cycle = 0;
    bit            model_valid = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_beats = 0;

    // Behavioural model: a request accepted in cycle T reads word
    // (start+k) mod DEPTH in cycle T+1+k (old contents if written in that
    // same cycle) and shows it in cycle T+2+k. The responder is free again
    // in cycle T+1+N. Reset cancels everything still pending.
    always @(posedge clk) begin
        longint c;
        c = cyc;
        if (rst) begin
            sched.delete();
            expq.delete();
            free_cycle = c + 1;
        end else begin
            while (sched.size() > 0 && sched[0].cyc == c) begin
                read_t r;
                beat_t b;
                r = sched.pop_front();
                b.data = ref_mem[r.addr];
                b.last = r.last;
                b.due  = c + 1;
                expq.push_back(b);
            end
            if (arvalid && c >= free_cycle) begin
                int n;
                n = int'(arburst) + 1;
                for (int k = 0; k < n; k++) begin
                    read_t r;
                    r.cyc  = c + 1 + k;
                    r.addr = (araddr + 32'(k)) % DEPTH;
                    r.last = (k == n - 1);
                    sched.push_back(r);
                end
                free_cycle = c + 1 + n;
            end
        end
        if (wr_en) ref_mem[wr_addr] = wr_data;
        cyc = cyc + 1;
        model_valid = 1;
    end

    // Monitor: samples at the falling edge, pops the scoreboard on every beat.
    always @(negedge clk) begin
        if (model_valid) begin
            bit exp_ready;
            exp_ready = (cyc >= free_cycle);
            n_checks++;
            if (arready !== exp_ready) begin
                n_fail++;
                $display("[TB] FAIL arready cyc=%0d got=%b exp=%b", cyc, arready, exp_ready);
            end
            n_checks++;
            if (busy !== !exp_ready) begin
                n_fail++;
                $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !exp_ready);
            end
            if (rvalid === 1'b1) begin
                n_beats++;
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat cyc=%0d got rdata=%h exp=no beat", cyc, rdata);
                end else begin
                    beat_t b;
                    b = expq.pop_front();
                    n_checks++;
                    if (rdata !== b.data) begin
                        n_fail++;
                        $display("[TB] FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, b.data);
                    end
                    n_checks++;
                    if (rlast !== b.last) begin
                        n_fail++;
                        $display("[TB] FAIL rlast cyc=%0d got=%b exp=%b", cyc, rlast, b.last);
                    end
                    n_checks++;
                    if (cyc != b.due) begin
                        n_fail++;
                        $display("[TB] FAIL beat_timing got cyc=%0d exp cyc=%0d", cyc, b.due);
                    end
                end
            end else begin
                n_checks++;
                if (rvalid !== 1'b0 || rlast !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL idle_outputs cyc=%0d got rvalid=%b rlast=%b exp=0,0", cyc, rvalid, rlast);
                end
                if (expq.size() > 0 && expq[0].due <= cyc) begin
                    beat_t b;
                    b = expq.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL missing_beat cyc=%0d got rvalid=0 exp data=%h", cyc, b.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic writeWord(input int unsigned a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = 8'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Present a request and hold it until the handshake; returns at the
    // falling edge inside cycle T+1.
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [3:0] b, input bit keep);
        bit got;
        araddr  = a;
        arburst = b;
        arvalid = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            got = arready;
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL handshake_timeout got arready=0 exp=1 within 60 cycles");
        end
        if (!keep) arvalid = 1'b0;
    endtask

    task automatic checkOutput();
        n_checks++;
        if (expq.size() != 0 || sched.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain got pending=%0d exp=0", expq.size() + sched.size());
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        araddr  = '0;
        arvalid = 1'b0;
        arburst = '0;
        tick(3);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 32; i++) writeWord(i, 32'h100 + 32'(i));
        applyStimulus(32'h0, 4'd8, 1'b0);
        tick(14);

        writeWord(254, 32'hA);
        writeWord(255, 32'hB);
        writeWord(0, 32'hC);
        writeWord(1, 32'hD);
        applyStimulus(32'h1FE, 4'd3, 1'b0);
        tick(8);

        writeWord(0, 32'h100);
        applyStimulus(32'h0, 4'd0, 1'b1);
        applyStimulus(32'h4, 4'd1, 1'b0);
        tick(6);

        // Collision: mem[10] written in T+1, mem[2] written as beat 2 is read.
        applyStimulus(32'h0, 4'd15, 1'b0);
        wr_en = 1'b1; wr_addr = 8'd10; wr_data = 32'hDEAD;
        tick(1);
        wr_en = 1'b0;
        tick(1);
        wr_en = 1'b1; wr_addr = 8'd2; wr_data = 32'hBEEF;
        tick(1);
        wr_en = 1'b0;
        tick(18);

        // Reset in cycle T+5 of a 16-beat burst.
        applyStimulus(32'h0, 4'd15, 1'b0);
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        applyStimulus(32'h8, 4'd1, 1'b0);
        tick(6);

        // Randomized traffic with concurrent preload writes.
        fork
            begin
                for (int r = 0; r < 25; r++) begin
                    applyStimulus($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                    tick($urandom_range(0, 3));
                end
                arvalid = 1'b0;
            end
            begin
                for (int w = 0; w < 300; w++) begin
                    wr_en   = 1'($urandom_range(0, 1));
                    wr_addr = 8'($urandom);
                    wr_data = $urandom;
                    tick(1);
                end
                wr_en = 1'b0;
            end
        join
        tick(25);
        checkOutput();
        n_checks++;
        if (n_beats < 40) begin
            n_fail++;
            $display("[TB] FAIL beat_count got=%0d exp>=40", n_beats);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout got running exp finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
